// File: rtl/alu_exec_unit.sv
// alu_exec_unit: multi-cycle execute unit for the EX stage.
// Single-cycle ops finish in one cycle. Shifts iterate one bit per cycle,
// and multiply runs a shift-add loop with one multiplier bit per cycle.
// One op is in flight at a time, with valid/ready handshakes on both sides.
module alu_exec_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            operation,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  zero,
    output logic                  branch_taken,
    output logic                  illegal_op
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_BNE = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_SLL = 4'b0101;
    localparam logic [3:0] OP_SRL = 4'b0110;
    localparam logic [3:0] OP_SRA = 4'b0111;
    localparam logic [3:0] OP_BEQ = 4'b1000;
    localparam logic [3:0] OP_MUL = 4'b1001;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_MUL   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // One extra bit so the counter can hold DATA_WIDTH for the multiply loop.
    localparam int CNT_W = SHAMT_W + 1;

    logic [1:0]            state;
    logic [3:0]            op_r;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] mcand;
    logic [DATA_WIDTH-1:0] mplier;
    logic [SHAMT_W-1:0]    shamt;
    logic                  is_shift;
    logic [DATA_WIDTH-1:0] simple_res;
    logic [DATA_WIDTH-1:0] shift_next;
    logic [DATA_WIDTH-1:0] mul_next;

    // Result of every op that completes in the accept cycle. Shift codes
    // only reach here with a zero shift amount, so they pass a through.
    function automatic logic [DATA_WIDTH-1:0] simple_op(input logic [3:0] op,
                                                        input logic [DATA_WIDTH-1:0] x,
                                                        input logic [DATA_WIDTH-1:0] y);
        case (op)
            OP_AND:                 simple_op = x & y;
            OP_OR:                  simple_op = x | y;
            OP_ADD:                 simple_op = x + y;
            OP_SUB, OP_BNE, OP_BEQ: simple_op = x - y;
            OP_SLL, OP_SRL, OP_SRA: simple_op = x;
            default:                simple_op = '0;
        endcase
    endfunction

    function automatic logic branch_cond(input logic [3:0] op,
                                         input logic [DATA_WIDTH-1:0] x,
                                         input logic [DATA_WIDTH-1:0] y);
        branch_cond = ((op == OP_BNE) && (x != y)) || ((op == OP_BEQ) && (x == y));
    endfunction

    // A single one-bit step of the shifter. SRA refills from the sign bit.
    function automatic logic [DATA_WIDTH-1:0] shift_one(input logic [3:0] op,
                                                        input logic [DATA_WIDTH-1:0] x);
        case (op)
            OP_SLL:  shift_one = x << 1;
            OP_SRL:  shift_one = x >> 1;
            default: shift_one = {x[DATA_WIDTH-1], x[DATA_WIDTH-1:1]};
        endcase
    endfunction

    assign shamt      = b[SHAMT_W-1:0];
    assign is_shift   = (operation == OP_SLL) || (operation == OP_SRL) || (operation == OP_SRA);
    assign in_ready   = !reset && (state == S_IDLE);
    assign simple_res = simple_op(operation, a, b);

    // Next accumulator values for the iterative shift and shift-add multiply.
    always_comb begin
        shift_next = shift_one(op_r, acc);
        mul_next   = acc + (mplier[0] ? mcand : '0);
    end

    // Control FSM and the architecturally visible output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            op_r         <= '0;
            cnt          <= '0;
            out_valid    <= 1'b0;
            result       <= '0;
            zero         <= 1'b0;
            branch_taken <= 1'b0;
            illegal_op   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_r <= operation;
                        if (is_shift && (shamt != '0)) begin
                            state <= S_SHIFT;
                            cnt   <= {1'b0, shamt};
                        end else if (operation == OP_MUL) begin
                            state <= S_MUL;
                            cnt   <= CNT_W'(DATA_WIDTH);
                        end else begin
                            state        <= S_DONE;
                            out_valid    <= 1'b1;
                            result       <= simple_res;
                            zero         <= (simple_res == '0);
                            branch_taken <= branch_cond(operation, a, b);
                            illegal_op   <= (operation > OP_MUL);
                        end
                    end
                end
                S_SHIFT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state        <= S_DONE;
                        out_valid    <= 1'b1;
                        result       <= shift_next;
                        zero         <= (shift_next == '0);
                        branch_taken <= 1'b0;
                        illegal_op   <= 1'b0;
                    end
                end
                S_MUL: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state        <= S_DONE;
                        out_valid    <= 1'b1;
                        result       <= mul_next;
                        zero         <= (mul_next == '0);
                        branch_taken <= 1'b0;
                        illegal_op   <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Iteration datapath. It needs no reset because it is always reloaded on accept.
    always_ff @(posedge clk) begin
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    acc    <= (operation == OP_MUL) ? '0 : a;
                    mcand  <= a;
                    mplier <= b;
                end
            end
            S_SHIFT: acc <= shift_next;
            S_MUL: begin
                acc    <= mul_next;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Multi-cycle execute unit for the RISC-V pipeline's EX stage; consumes the 4-bit Operation code from the ALU control decoder plus two operands.
- Produces the result, zero flag and branch decision.
- Single-cycle ops finish in 1 cycle; shifts and multiply iterate. Valid/ready handshakes on input and output stall the pipeline while busy.

Parameters:
- DATA_WIDTH, 32, operand/result width; power of two, >= 8.
- SHAMT_W, $clog2(DATA_WIDTH), shift-amount width taken from b.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operation/operands valid
- in_ready  output  1  unit can accept an operation
- operation  input  4  operation code from the ALU control decoder
- a  input  DATA_WIDTH  operand 1 (rs1)
- b  input  DATA_WIDTH  operand 2 (rs2/imm)
- out_valid  output  1  result valid, held until accepted
- out_ready  input  1  downstream accepts result
- result  output  DATA_WIDTH  operation result
- zero  output  1  result == 0
- branch_taken  output  1  branch condition true
- illegal_op  output  1  operation code not supported

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high.
- Reset values: state IDLE; out_valid 0, result 0, zero 0, branch_taken 0, illegal_op 0.
- in_ready is 0 while reset is high. Otherwise in_ready = (state == IDLE).
- Acceptance: in_valid && in_ready at a rising edge (call it cycle 0). operation, a and b are captured. Inputs are don't-care afterwards.
- Operation codes:
  - 0000 AND
  - 0001 SUB (a-b)
  - 0010 ADD (a+b, also load/store address)
  - 0011 BNE: result = a-b, branch_taken = (a != b)
  - 0100 OR
  - 0101 SLL
  - 0110 SRL
  - 0111 SRA
  - 1000 BEQ: result = a-b, branch_taken = (a == b)
  - 1001 MUL: low DATA_WIDTH bits of a*b
  - all others illegal: result 0, illegal_op 1, latency 1
- branch_taken is 0 for all non-branch codes.
- Arithmetic: all ADD/SUB results wrap modulo 2^DATA_WIDTH, with no overflow flag.
- Shift amount is b[SHAMT_W-1:0]; upper bits of b are ignored. SRA replicates a[DATA_WIDTH-1].
- States:
  - IDLE: on accept, simple/illegal ops go to DONE. Shifts with shamt 0 also go to DONE (result = a). Shifts with shamt > 0 go to SHIFT. MUL goes to MUL.
  - SHIFT: shift accumulator 1 bit per cycle; down-counter loaded with shamt. Go to DONE when it reaches 0.
  - MUL: shift-add, 1 multiplier bit per cycle, DATA_WIDTH cycles, then DONE.
  - DONE: out_valid = 1; result, zero, branch_taken and illegal_op are stable. Go to IDLE on out_ready.
- Latency: out_valid rises LAT cycles after the acceptance edge.
  - Simple, illegal, or shamt = 0: LAT = 1.
  - Shift: LAT = 1 + shamt.
  - MUL: LAT = 1 + DATA_WIDTH.
- Throughput: at most one op in flight. in_ready = 0 in SHIFT, MUL and DONE. After an out_ready handshake, in_ready is 1 in the next cycle.
- out_ready held high while out_valid is 1: the DONE to IDLE transition takes 1 cycle, so back-to-back simple ops give a result every 2 cycles.
- out_ready before DONE has no effect. Backpressure (out_ready = 0) holds all outputs unchanged indefinitely.
- out_valid drops the cycle after the handshake. result, zero, branch_taken and illegal_op keep their last values until the next op completes.
- zero is computed from the final result of every op, including branches.
- Reset mid-operation, in any state: aborts immediately, returns to IDLE with reset values, and no out_valid is produced for the aborted op.
- in_valid while not ready is ignored; the unit never captures in that case.

Test Plan:
- Reset: assert reset during MUL at cycle 10 -> out_valid 0 immediately, result 0. After release in_ready = 1 and no stale result appears.
- Simple ops, DATA_WIDTH = 32, out_ready = 1:
  - ADD a=0xFFFFFFFF, b=1 -> result 0, zero 1, LAT 1.
  - SUB 5-7 -> 0xFFFFFFFE.
  - AND/OR 0xF0F0, 0x0FF0 -> 0x00F0 / 0xFFF0.
- Branches:
  - BEQ a=b=0x1234 -> branch_taken 1, zero 1.
  - BNE a=3, b=4 -> branch_taken 1, result 0xFFFFFFFF, zero 0.
  - BNE a=b -> branch_taken 0.
- Shifts:
  - SLL a=1, b=0x25 (shamt 5) -> 0x20 with out_valid exactly 6 cycles after accept.
  - SRA a=0x80000000, shamt 31 -> 0xFFFFFFFF, LAT 32.
  - SRL shamt 0 -> a, LAT 1.
- MUL:
  - a=0x10001, b=0x10001 -> 0x00020001, LAT 33.
  - a=0xFFFFFFFF, b=0xFFFFFFFF -> 0x00000001.
  - in_ready stays 0 throughout.
- Handshake:
  - Hold out_ready = 0 for 5 cycles after DONE -> outputs stable and in_ready 0. Raise out_ready -> out_valid drops next cycle, in_ready 1.
  - Illegal code 1111 -> illegal_op 1, result 0, LAT 1.
